proto_matrix_sequencer: RTL and testbench
=========================================

Name: proto_matrix_sequencer

Overview:
Sequencer that walks the 4x24 rate-5/6 base (prototype) matrix held in the shared multi-Z prototype ROM (ProtoMatrixRom_MultiLUT, async read, 288x7). It emits one circulant-shift entry per cycle to the encoder/decoder datapath over a valid/ready stream.
- Null ("-") blocks are skipped.
- Each entry is tagged with its row and column.
- Sits between the LDPC top-level control and the ROM; the parent owns the ROM instance and ties rom_addr/rom_data to it.

Parameters:
- NUM_ROWS, 4, base-matrix rows
- NUM_COLS, 24, base-matrix columns
- DEPTH_PER_Z, 96, ROM entries per Z region (NUM_ROWS*NUM_COLS)
- WIDTH, 7, ROM data width; null code = 2**WIDTH-1 = 127
- ADDRW, 9, ROM address width

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a matrix walk
- z_sel  in  2  0=Z27 (base 0), 1=Z54 (base 96), 2=Z81 (base 192), 3=invalid
- abort  in  1  synchronous cancel of the current walk
- rom_addr  out  ADDRW  address to ROM, combinational from state
- rom_data  in  WIDTH  ROM read data, valid the same cycle as rom_addr
- out_valid  out  1  entry available
- out_ready  in  1  consumer accepts entry
- out_shift  out  WIDTH  circulant shift value
- out_row  out  2  base-matrix row 0..3
- out_col  out  5  base-matrix column 0..23
- busy  out  1  high from the cycle after an accepted start until done/abort
- done  out  1  one-cycle pulse when the walk completes and the last entry has drained
- out_count  out  7  non-null entries emitted this walk; holds after done
- cfg_err  out  1  sticky error; cleared by an accepted start

Behaviour:
- Reset: state IDLE. out_valid, busy, done, cfg_err = 0. out_shift, out_row, out_col, out_count = 0. rom_addr = 0.
- States:
  - IDLE -> SCAN: start=1 and z_sel<3. Latches base=z_sel*96, row=0, col=0; clears out_count and cfg_err.
  - IDLE, start=1 with z_sel=3: cfg_err=1, remain IDLE, busy stays 0.
  - start in any state other than IDLE: ignored.
- rom_addr = base + row*24 + col while in SCAN; otherwise 0.
- SCAN advance rule: advance when the output register can load, i.e. (!out_valid || out_ready).
  - On advance, if rom_data != 127: load out_shift=rom_data, out_row, out_col; set out_valid; increment out_count.
  - On advance, if rom_data == 127: nothing is loaded. If out_ready consumed the held entry, out_valid drops. The null is skipped in one cycle.
  - On advance, col increments; at col=23 it wraps to 0 and row increments.
  - Advancing past (3,23) moves to DRAIN.
  - No advance (output stalled): row, col and rom_addr hold.
- Non-null rom_data >= Z (selected 27/54/81): cfg_err=1; the entry is still emitted unchanged.
- Throughput and latency:
  - 1 entry per cycle with out_ready held high.
  - First out_valid at start+2 cycles (start cycle, then first SCAN cycle loads).
  - A full walk takes exactly 96 SCAN cycles when never stalled.
- DRAIN: when out_valid==0, or out_valid && out_ready, pulse done for one cycle, drop busy, go to IDLE.
- out_valid, once high, holds with stable out_shift/out_row/out_col until out_ready.
- abort (any state, priority over start and advance): next cycle IDLE, out_valid=0, busy=0, no done; out_count and cfg_err hold.
- Async rst mid-walk: immediate return to reset values.

Decomposition:
- Package ldpc_pkg holds:
  - NUM_ROWS, NUM_COLS, DEPTH_PER_Z, NULL_CODE
  - Z_LUT {27,54,81}
  - typedef enum logic[1:0] z_sel_t
  - typedef enum logic[1:0] seq_state_t {IDLE, SCAN, DRAIN}
- One sub-module: proto_rc_counter, the row/col counter with enable, wrap and terminal flag.
- The ROM is not instantiated inside this block.

Test Plan:
- Stub ROM with all 96 Z54 entries = 5, z_sel=1, out_ready=1 -> rom_addr runs 96..191, 96 beats of shift 5, first beat row0/col0, last beat row3/col23, done at cycle 98 after start, out_count=96.
- Z27 region with only (0,3)=7, (2,10)=0, (3,23)=26 non-null, rest 127 -> exactly 3 beats with those row/col/shift values, done after the walk, out_count=3, cfg_err=0.
- Same as the first scenario with out_ready toggling 1,0,0,1 -> no beat lost or duplicated, payload stable while stalled, rom_addr frozen during the stall.
- z_sel=3 start -> cfg_err=1, busy=0, no out_valid. A following valid start clears cfg_err.
- Z27 entry (1,5)=30 -> beat emitted with shift 30 and cfg_err set sticky.
- abort after 10 beats -> out_valid=0 and IDLE next cycle, no done pulse. A new start replays from row0/col0 with out_count cleared.

Source files
------------

// File: rtl/ldpc_pkg.sv
// Shared constants and types for the prototype-matrix sequencer.
package ldpc_pkg;

   localparam int unsigned NUM_ROWS    = 4;
   localparam int unsigned NUM_COLS    = 24;
   localparam int unsigned DEPTH_PER_Z = NUM_ROWS * NUM_COLS;
   localparam int unsigned WIDTH       = 7;
   localparam int unsigned ADDRW       = 9;
   localparam int unsigned ROWW        = 2;
   localparam int unsigned COLW        = 5;
   localparam int unsigned CNTW        = 7;

   localparam logic [WIDTH-1:0] NULL_CODE = {WIDTH{1'b1}};

   // Lifting size per region, index 0 = Z27.
   localparam logic [2:0][WIDTH-1:0] Z_LUT = {7'd81, 7'd54, 7'd27};

   typedef enum logic [1:0] {
      Z27   = 2'd0,
      Z54   = 2'd1,
      Z81   = 2'd2,
      Z_INV = 2'd3
   } z_sel_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2
   } seq_state_t;

   // Lifting size for a region selector; the invalid code never reaches a walk.
   function automatic logic [WIDTH-1:0] z_of(input z_sel_t s);
      case (s)
         Z27:     z_of = Z_LUT[0];
         Z54:     z_of = Z_LUT[1];
         default: z_of = Z_LUT[2];
      endcase
   endfunction

   // First ROM address of a region.
   function automatic logic [ADDRW-1:0] base_of(input z_sel_t s);
      base_of = ADDRW'(DEPTH_PER_Z) * ADDRW'(s);
   endfunction

endpackage

// File: rtl/proto_rc_counter.sv
// Row/column walker over the base matrix with clear, enable and terminal flag.
module proto_rc_counter
   import ldpc_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   input  logic            en,
   output logic [ROWW-1:0] row,
   output logic [COLW-1:0] col,
   output logic            last_c
);

   // Terminal position is the bottom-right block.
   assign last_c = (row == ROWW'(NUM_ROWS - 1)) && (col == COLW'(NUM_COLS - 1));

   // Column-major-within-row step; wraps to (0,0) after the terminal block.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row <= '0;
         col <= '0;
      end else if (clr) begin
         row <= '0;
         col <= '0;
      end else if (en) begin
         if (col == COLW'(NUM_COLS - 1)) begin
            col <= '0;
            row <= (row == ROWW'(NUM_ROWS - 1)) ? '0 : row + ROWW'(1);
         end else begin
            col <= col + COLW'(1);
         end
      end
   end

endmodule

// File: rtl/proto_matrix_sequencer.sv
// Walks the base matrix in ROM and streams non-null circulant shifts.
module proto_matrix_sequencer
   import ldpc_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       z_sel,
   input  logic             abort,
   output logic [ADDRW-1:0] rom_addr,
   input  logic [WIDTH-1:0] rom_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_shift,
   output logic [ROWW-1:0]  out_row,
   output logic [COLW-1:0]  out_col,
   output logic             busy,
   output logic             done,
   output logic [CNTW-1:0]  out_count,
   output logic             cfg_err
);

   seq_state_t       state, state_nxt;
   logic [ADDRW-1:0] base, base_nxt;
   logic [WIDTH-1:0] z_val, z_nxt;
   logic             valid_nxt, busy_nxt, done_nxt, err_nxt;
   logic [WIDTH-1:0] shift_nxt;
   logic [ROWW-1:0]  orow_nxt;
   logic [COLW-1:0]  ocol_nxt;
   logic [CNTW-1:0]  count_nxt;

   logic [ROWW-1:0]  row;
   logic [COLW-1:0]  col;
   logic             last_c;
   logic             accept_c;
   logic             adv_c;

   // A start is only taken from IDLE with a legal region and no abort.
   assign accept_c = (state == IDLE) && start && (z_sel_t'(z_sel) != Z_INV) && !abort;
   // The scan moves on whenever the output register is free to load.
   assign adv_c    = (state == SCAN) && (!out_valid || out_ready) && !abort;

   proto_rc_counter u_rc (
      .clk    (clk),
      .rst    (rst),
      .clr    (accept_c),
      .en     (adv_c),
      .row    (row),
      .col    (col),
      .last_c (last_c)
   );

   // ROM address tracks the walk position only while scanning.
   always_comb begin
      rom_addr = '0;
      if (state == SCAN)
         rom_addr = base + ADDRW'(row) * ADDRW'(NUM_COLS) + ADDRW'(col);
   end

   // State register and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         base      <= '0;
         z_val     <= '0;
         out_valid <= 1'b0;
         out_shift <= '0;
         out_row   <= '0;
         out_col   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         out_count <= '0;
         cfg_err   <= 1'b0;
      end else begin
         state     <= state_nxt;
         base      <= base_nxt;
         z_val     <= z_nxt;
         out_valid <= valid_nxt;
         out_shift <= shift_nxt;
         out_row   <= orow_nxt;
         out_col   <= ocol_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         out_count <= count_nxt;
         cfg_err   <= err_nxt;
      end
   end

   // Next-state and next-output logic; abort overrides everything at the end.
   always_comb begin
      state_nxt = state;
      base_nxt  = base;
      z_nxt     = z_val;
      valid_nxt = out_valid;
      shift_nxt = out_shift;
      orow_nxt  = out_row;
      ocol_nxt  = out_col;
      busy_nxt  = busy;
      done_nxt  = 1'b0;
      count_nxt = out_count;
      err_nxt   = cfg_err;

      case (state)
         IDLE: begin
            if (accept_c) begin
               state_nxt = SCAN;
               base_nxt  = base_of(z_sel_t'(z_sel));
               z_nxt     = z_of(z_sel_t'(z_sel));
               count_nxt = '0;
               err_nxt   = 1'b0;
               busy_nxt  = 1'b1;
            end else if (start && (z_sel_t'(z_sel) == Z_INV)) begin
               err_nxt = 1'b1;
            end
         end
         SCAN: begin
            if (out_valid && out_ready)
               valid_nxt = 1'b0;
            if (adv_c) begin
               if (rom_data != NULL_CODE) begin
                  valid_nxt = 1'b1;
                  shift_nxt = rom_data;
                  orow_nxt  = row;
                  ocol_nxt  = col;
                  count_nxt = out_count + CNTW'(1);
                  if (rom_data >= z_val)
                     err_nxt = 1'b1;
               end
               if (last_c)
                  state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (!out_valid || out_ready) begin
               valid_nxt = 1'b0;
               done_nxt  = 1'b1;
               busy_nxt  = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (abort) begin
         state_nxt = IDLE;
         valid_nxt = 1'b0;
         busy_nxt  = 1'b0;
         done_nxt  = 1'b0;
      end
   end

endmodule

// File: tb/tb_proto_matrix_sequencer.sv
// Directed self-checking bench for proto_matrix_sequencer with a stub ROM.
module tb_proto_matrix_sequencer;

   localparam int MAXC = 600;

   logic       clk = 1'b0;
   logic       rst, start, abort, out_ready;
   logic [1:0] z_sel;
   logic [8:0] rom_addr;
   logic [6:0] rom_data;
   logic       out_valid, busy, done, cfg_err;
   logic [6:0] out_shift, out_count;
   logic [1:0] out_row;
   logic [4:0] out_col;

   logic [6:0] rom [0:511];
   assign rom_data = rom[rom_addr];

   int passed = 0;
   int total  = 0;

   // Per-cycle logs of one walk (index k = sample after the k-th edge past start).
   logic [8:0] addr_log [0:MAXC];
   logic       v_log    [0:MAXC];
   logic       rdy_log  [0:MAXC];
   logic       busy_log [0:MAXC];
   logic       err_log  [0:MAXC];
   logic       dn_log   [0:MAXC];
   logic [6:0] sh_log   [0:MAXC];
   logic [1:0] row_log  [0:MAXC];
   logic [4:0] col_log  [0:MAXC];
   logic [6:0] cnt_log  [0:MAXC];
   logic [6:0] b_sh  [$];
   logic [1:0] b_row [$];
   logic [4:0] b_col [$];
   int         done_cycle, abort_cycle, n_cycles;

   proto_matrix_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .z_sel     (z_sel),
      .abort     (abort),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_shift (out_shift),
      .out_row   (out_row),
      .out_col   (out_col),
      .busy      (busy),
      .done      (done),
      .out_count (out_count),
      .cfg_err   (cfg_err)
   );

   always #5 clk = ~clk;

   function automatic logic pat(input int mode, input int k);
      if (mode == 0) return 1'b1;
      case (k % 4)
         0, 3:    return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic fill_rom(input int base, input logic [6:0] v);
      for (int i = 0; i < 512; i++) rom[i] = 7'd127;
      for (int i = 0; i < 96; i++) rom[base + i] = v;
   endtask

   // Starts a walk and records outputs each cycle until done or the abort window ends.
   task automatic run_walk(input logic [1:0] zs, input int mode, input int abort_after);
      b_sh.delete(); b_row.delete(); b_col.delete();
      done_cycle = -1; abort_cycle = -1; n_cycles = 0;
      @(posedge clk); #1;
      start = 1'b1; z_sel = zs;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < MAXC; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         abort       = 1'b0;
         out_ready   = pat(mode, k);
         addr_log[k] = rom_addr;  v_log[k]   = out_valid; rdy_log[k] = out_ready;
         busy_log[k] = busy;      err_log[k] = cfg_err;   dn_log[k]  = done;
         sh_log[k]   = out_shift; row_log[k] = out_row;   col_log[k] = out_col;
         cnt_log[k]  = out_count;
         n_cycles    = k + 1;
         if (out_valid && out_ready) begin
            b_sh.push_back(out_shift); b_row.push_back(out_row); b_col.push_back(out_col);
         end
         if (done) begin done_cycle = k; break; end
         if (abort_after > 0 && abort_cycle < 0 && b_sh.size() == abort_after) begin
            abort = 1'b1; abort_cycle = k;
         end
         if (abort_cycle >= 0 && k >= abort_cycle + 5) break;
      end
      abort = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1; z_sel = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      if ({out_valid, busy, done, cfg_err} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {out_valid, busy, done, cfg_err});
      else passed++;
      total++;
      if ({out_shift, out_row, out_col, out_count} !== 21'd0) $display("FAIL reset_payload got %0h want 0", {out_shift, out_row, out_col, out_count});
      else passed++;
      total++;
      if (rom_addr !== 9'd0) $display("FAIL reset_addr got %0d want 0", rom_addr);
      else passed++;
      total++;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_full_walk;
      int errs;
      fill_rom(96, 7'd5);
      run_walk(2'd1, 0, 0);
      errs = 0;
      for (int k = 0; k < 96; k++) if (addr_log[k] !== 9'(96 + k)) errs++;
      if (errs != 0) $display("FAIL full_addr_seq got %0d bad addresses want 0", errs);
      else passed++;
      total++;
      if (b_sh.size() != 96) $display("FAIL full_beats got %0d want 96", b_sh.size());
      else passed++;
      total++;
      errs = 0;
      for (int i = 0; i < b_sh.size(); i++)
         if (b_sh[i] !== 7'd5 || b_row[i] !== 2'(i / 24) || b_col[i] !== 5'(i % 24)) errs++;
      if (errs != 0) $display("FAIL full_payload got %0d bad beats want 0", errs);
      else passed++;
      total++;
      if ({v_log[0], v_log[1]} !== 2'b01) $display("FAIL full_first_valid got %b want 01", {v_log[0], v_log[1]});
      else passed++;
      total++;
      if (b_sh.size() > 0 && {b_row[0], b_col[0], b_row[b_row.size()-1], b_col[b_col.size()-1]} !== {2'd0, 5'd0, 2'd3, 5'd23})
         $display("FAIL full_first_last got %0h want %0h", {b_row[0], b_col[0], b_row[b_row.size()-1], b_col[b_col.size()-1]}, {2'd0, 5'd0, 2'd3, 5'd23});
      else passed++;
      total++;
      if (done_cycle != 97) $display("FAIL full_done_cycle got %0d want 97", done_cycle);
      else passed++;
      total++;
      if (done_cycle == 97 && (cnt_log[97] !== 7'd96 || busy_log[96] !== 1'b1 || busy_log[97] !== 1'b0 || busy_log[0] !== 1'b1))
         $display("FAIL full_count_busy got cnt=%0d busy0=%b busy96=%b busy97=%b want 96 1 1 0", cnt_log[97], busy_log[0], busy_log[96], busy_log[97]);
      else passed++;
      total++;
      @(posedge clk); #1;
      if ({done, out_valid, busy} !== 3'b000) $display("FAIL full_after_done got %b want 000", {done, out_valid, busy});
      else passed++;
      total++;
   endtask

   task automatic test_stall;
      int errs, fz;
      fill_rom(96, 7'd5);
      run_walk(2'd1, 1, 0);
      if (b_sh.size() != 96) $display("FAIL stall_beats got %0d want 96", b_sh.size());
      else passed++;
      total++;
      errs = 0;
      for (int i = 0; i < b_sh.size(); i++)
         if (b_sh[i] !== 7'd5 || b_row[i] !== 2'(i / 24) || b_col[i] !== 5'(i % 24)) errs++;
      if (errs != 0) $display("FAIL stall_order got %0d bad beats want 0", errs);
      else passed++;
      total++;
      errs = 0; fz = 0;
      for (int k = 0; k + 1 < n_cycles; k++)
         if (v_log[k] && !rdy_log[k]) begin
            if ({v_log[k+1], sh_log[k+1], row_log[k+1], col_log[k+1]} !== {v_log[k], sh_log[k], row_log[k], col_log[k]}) errs++;
            if (addr_log[k+1] !== addr_log[k]) fz++;
         end
      if (errs != 0) $display("FAIL stall_payload_stable got %0d changes want 0", errs);
      else passed++;
      total++;
      if (fz != 0) $display("FAIL stall_addr_frozen got %0d changes want 0", fz);
      else passed++;
      total++;
      if (done_cycle < 0 || cnt_log[done_cycle] !== 7'd96) $display("FAIL stall_done got cycle=%0d want done with count 96", done_cycle);
      else passed++;
      total++;
   endtask

   task automatic test_abort;
      int dn;
      fill_rom(96, 7'd5);
      run_walk(2'd1, 0, 10);
      if (b_sh.size() != 10 || abort_cycle != 10) $display("FAIL abort_beats got %0d at %0d want 10 at 10", b_sh.size(), abort_cycle);
      else passed++;
      total++;
      if (abort_cycle >= 0 && {v_log[abort_cycle+1], busy_log[abort_cycle+1]} !== 2'b00)
         $display("FAIL abort_idle got %b want 00", {v_log[abort_cycle+1], busy_log[abort_cycle+1]});
      else passed++;
      total++;
      dn = 0;
      for (int k = 0; k < n_cycles; k++) if (dn_log[k]) dn++;
      if (dn != 0 || done_cycle != -1) $display("FAIL abort_no_done got %0d pulses want 0", dn);
      else passed++;
      total++;
      if (abort_cycle >= 0 && cnt_log[abort_cycle+1] !== 7'd10) $display("FAIL abort_count_hold got %0d want 10", cnt_log[abort_cycle+1]);
      else passed++;
      total++;
      run_walk(2'd1, 0, 0);
      if (cnt_log[0] !== 7'd0) $display("FAIL replay_count_clear got %0d want 0", cnt_log[0]);
      else passed++;
      total++;
      if (b_sh.size() != 96 || b_row[0] !== 2'd0 || b_col[0] !== 5'd0 || done_cycle != 97)
         $display("FAIL replay_walk got beats=%0d done=%0d want 96 97", b_sh.size(), done_cycle);
      else passed++;
      total++;
   endtask

   task automatic load_sparse;
      for (int i = 0; i < 512; i++) rom[i] = 7'd127;
      rom[3] = 7'd7; rom[58] = 7'd0; rom[95] = 7'd26;
   endtask

   task automatic test_sparse;
      logic [13:0] want [3];
      logic [13:0] got;
      load_sparse();
      run_walk(2'd0, 0, 0);
      want[0] = {2'd0, 5'd3, 7'd7}; want[1] = {2'd2, 5'd10, 7'd0}; want[2] = {2'd3, 5'd23, 7'd26};
      if (b_sh.size() != 3) $display("FAIL sparse_beats got %0d want 3", b_sh.size());
      else passed++;
      total++;
      for (int i = 0; i < 3; i++) begin
         got = (b_sh.size() > i) ? {b_row[i], b_col[i], b_sh[i]} : 14'h3fff;
         if (got !== want[i]) $display("FAIL sparse_beat%0d got %0h want %0h", i, got, want[i]);
         else passed++;
         total++;
      end
      if (done_cycle != 97 || cnt_log[97] !== 7'd3 || err_log[97] !== 1'b0)
         $display("FAIL sparse_done got cycle=%0d cnt=%0d err=%b want 97 3 0", done_cycle, cnt_log[97], err_log[97]);
      else passed++;
      total++;
   endtask

   task automatic test_bad_zsel;
      @(posedge clk); #1;
      start = 1'b1; z_sel = 2'd3;
      @(posedge clk); #1;
      start = 1'b0;
      if ({cfg_err, busy, out_valid} !== 3'b100) $display("FAIL badz_flags got %b want 100", {cfg_err, busy, out_valid});
      else passed++;
      total++;
      repeat (3) @(posedge clk);
      #1;
      if ({cfg_err, busy, out_valid, rom_addr} !== {3'b100, 9'd0}) $display("FAIL badz_stays_idle got %0h want %0h", {cfg_err, busy, out_valid, rom_addr}, {3'b100, 9'd0});
      else passed++;
      total++;
      load_sparse();
      run_walk(2'd0, 0, 0);
      if (err_log[0] !== 1'b0 || busy_log[0] !== 1'b1) $display("FAIL badz_clear got err=%b busy=%b want 0 1", err_log[0], busy_log[0]);
      else passed++;
      total++;
   endtask

   task automatic test_shift_range;
      int idx;
      load_sparse();
      rom[29] = 7'd30;
      run_walk(2'd0, 0, 0);
      idx = -1;
      for (int i = 0; i < b_sh.size(); i++) if (b_row[i] == 2'd1 && b_col[i] == 5'd5) idx = i;
      if (b_sh.size() != 4 || idx != 1 || b_sh[1] !== 7'd30) $display("FAIL range_beat got beats=%0d idx=%0d want 4 1", b_sh.size(), idx);
      else passed++;
      total++;
      if ({err_log[29], err_log[30]} !== 2'b01) $display("FAIL range_err_edge got %b want 01", {err_log[29], err_log[30]});
      else passed++;
      total++;
      repeat (4) @(posedge clk);
      #1;
      if (cfg_err !== 1'b1 || out_count !== 7'd4) $display("FAIL range_sticky got err=%b cnt=%0d want 1 4", cfg_err, out_count);
      else passed++;
      total++;
   endtask

   task automatic test_async_reset;
      fill_rom(96, 7'd5);
      @(posedge clk); #1;
      start = 1'b1; z_sel = 2'd1; out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (20) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      if ({out_valid, busy, done, cfg_err, rom_addr, out_count, out_shift} !== 27'd0)
         $display("FAIL async_reset got %0h want 0", {out_valid, busy, done, cfg_err, rom_addr, out_count, out_shift});
      else passed++;
      total++;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      for (int i = 0; i < 512; i++) rom[i] = 7'd127;
      test_reset();
      test_full_walk();
      test_stall();
      test_abort();
      test_sparse();
      test_bad_zsel();
      test_shift_range();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
